// File: rtl/dm_hs.sv
// Byte-addressable data memory with a req/ready/valid handshake and a registered read.
// Supports byte/half/word access, sign or zero extension, and misalignment faults.
module dm_hs_lane #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wd,
  output logic [7:0]        rd
);
  logic [7:0] mem [2**ADDR_W] = '{default: '0};

  // The read captures the pre-write contents; a load never shares an accept edge with a store.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wd;
    if (en) rd <= mem[addr];
  end
endmodule

module dm_hs #(
  parameter  int DEPTH_WORDS = 64,
  localparam int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] rd_o,
  output logic        fault_o
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]       state;
  logic             accept, misalign;
  logic [3:0]       lane_mask;
  logic [3:0][7:0]  wd_lane, rdw;
  logic             we_q, uns_q, fault_q;
  logic [1:0]       size_q, off_q;
  logic [31:0]      rd_ext;
  logic [7:0]       sel_b;
  logic [15:0]      sel_h;
  logic             unused_hi;

  assign unused_hi = ^a_i[31:ADDR_W+2];

  assign ready_o = (state == IDLE) & ~rst_i;
  assign accept  = req_i & ready_o;

  always_comb begin
    misalign  = 1'b1;
    lane_mask = 4'b0000;
    wd_lane   = wd_i;
    case (size_i)
      2'b00: begin
        misalign  = 1'b0;
        lane_mask = 4'b0001 << a_i[1:0];
        wd_lane   = {4{wd_i[7:0]}};
      end
      2'b01: begin
        misalign  = a_i[0];
        lane_mask = a_i[1] ? 4'b1100 : 4'b0011;
        wd_lane   = {2{wd_i[15:0]}};
      end
      2'b10: begin
        misalign  = |a_i[1:0];
        lane_mask = 4'b1111;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    dm_hs_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk  (clk_i),
      .en   (accept),
      .we   (accept & we_i & ~misalign & lane_mask[i]),
      .addr (a_i[ADDR_W+1:2]),
      .wd   (wd_lane[i]),
      .rd   (rdw[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state   <= RESP;
          we_q    <= we_i;
          uns_q   <= uns_i;
          fault_q <= misalign;
          size_q  <= size_i;
          off_q   <= a_i[1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sel_b = rdw[off_q];
  assign sel_h = off_q[1] ? {rdw[3], rdw[2]} : {rdw[1], rdw[0]};

  always_comb begin
    case (size_q)
      2'b00:   rd_ext = {{24{~uns_q & sel_b[7]}}, sel_b};
      2'b01:   rd_ext = {{16{~uns_q & sel_h[15]}}, sel_h};
      default: rd_ext = rdw;
    endcase
  end

  // A reset landing in the response cycle suppresses the strobe.
  assign valid_o = (state == RESP) & ~rst_i;
  assign fault_o = valid_o & fault_q;
  assign rd_o    = (valid_o & ~fault_q & ~we_q) ? rd_ext : 32'h0;
endmodule

// File: tb/tb_dm_hs.sv
// Directed-vector bench for dm_hs: table of single transactions plus handshake/reset sequences.
module tb_dm_hs;
  logic        clk_i = 1'b0, rst_i = 1'b1, req_i = 1'b0, we_i = 1'b0, uns_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic [31:0] a_i = '0, wd_i = '0;
  logic        ready_o, valid_o, fault_o;
  logic [31:0] rd_o;

  int n_cmp = 0, n_bad = 0;

  dm_hs #(.DEPTH_WORDS(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .uns_i(uns_i), .a_i(a_i), .wd_i(wd_i), .ready_o(ready_o), .valid_o(valid_o),
    .rd_o(rd_o), .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_fault;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge, then checks the response cycle and the return to idle.
  task automatic txn(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk_i);
    req_i = 1'b1; we_i = v.we; size_i = v.size; uns_i = v.uns; a_i = v.a; wd_i = v.wd;
    @(negedge clk_i);
    req_i = 1'b0;
    chk({nm, ".valid"}, {31'b0, valid_o}, 32'h1);
    chk({nm, ".ready"}, {31'b0, ready_o}, 32'h0);
    chk({nm, ".rd"},    rd_o, v.exp_rd);
    chk({nm, ".fault"}, {31'b0, fault_o}, {31'b0, v.exp_fault});
    @(negedge clk_i);
    chk({nm, ".valid_off"}, {31'b0, valid_o}, 32'h0);
    chk({nm, ".ready_on"},  {31'b0, ready_o}, 32'h1);
  endtask

  vec_t vt [18];
  vec_t ops [4];

  initial begin
    //          we    size   uns   addr           wd            exp_rd        fault
    vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b0};
    vt[1]  = '{1'b1, 2'b10, 1'b0, 32'h7100_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
    vt[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
    vt[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_0080, 32'h0000_0000, 1'b0};
    vt[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'hFFFFFF80, 1'b0};
    vt[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'h0000_0080, 1'b0};
    vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h80ADBEEF, 1'b0};
    vt[7]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'hFFFF80AD, 1'b0};
    vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1};
    vt[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0016, 32'h12345678, 32'h0000_0000, 1'b1};
    vt[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h0000_0000, 1'b0};
    vt[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0014, 32'h0,        32'h0000_0000, 1'b1};
    vt[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'hAAAA5566, 32'h0000_0000, 1'b0};
    vt[13] = '{1'b0, 2'b01, 1'b1, 32'h0000_0016, 32'h0,        32'h0000_5566, 1'b0};
    vt[14] = '{1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        32'h55660000, 1'b0};
    vt[15] = '{1'b0, 2'b00, 1'b0, 32'h0000_0017, 32'h0,        32'h0000_0055, 1'b0};
    vt[16] = '{1'b1, 2'b00, 1'b0, 32'h0000_03FC, 32'h0000_01FF, 32'h0000_0000, 1'b0};
    vt[17] = '{1'b0, 2'b00, 1'b0, 32'h0000_00FC, 32'h0,        32'hFFFFFFFF, 1'b0};

    ops[0] = '{1'b1, 2'b10, 1'b0, 32'h40, 32'h11111111, 32'h0, 1'b0};
    ops[1] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h11111111, 1'b0};
    ops[2] = '{1'b1, 2'b10, 1'b0, 32'h44, 32'h22222222, 32'h0, 1'b0};
    ops[3] = '{1'b0, 2'b10, 1'b0, 32'h44, 32'h0,        32'h22222222, 1'b0};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst.ready", {31'b0, ready_o}, 32'h0);
    chk("rst.valid", {31'b0, valid_o}, 32'h0);
    chk("rst.rd", rd_o, 32'h0);
    chk("rst.fault", {31'b0, fault_o}, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst.ready", {31'b0, ready_o}, 32'h1);
    chk("post_rst.valid", {31'b0, valid_o}, 32'h0);

    for (int i = 0; i < 18; i++) txn(i, vt[i]);

    // Back-to-back requests with req_i held high
    begin
      int k;
      k = 0;
      req_i = 1'b1;
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("b2b.ready%0d", c), {31'b0, ready_o}, {31'b0, (c % 2) == 0});
        chk($sformatf("b2b.valid%0d", c), {31'b0, valid_o}, {31'b0, (c % 2) == 1});
        if ((c % 2) == 1 && !ops[c/2].we)
          chk($sformatf("b2b.rd%0d", c), rd_o, ops[c/2].exp_rd);
        if (ready_o && k < 4) begin
          we_i = ops[k].we; size_i = ops[k].size; uns_i = ops[k].uns;
          a_i = ops[k].a; wd_i = ops[k].wd;
          k++;
        end
        @(negedge clk_i);
      end
      req_i = 1'b0;
      chk("b2b.accepts", k, 4);
      chk("b2b.tail_valid", {31'b0, valid_o}, 32'h0);
    end

    // Reset during the response cycle of a load
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; a_i = 32'h10;
    @(negedge clk_i);
    req_i = 1'b0; rst_i = 1'b1;
    #1;
    chk("rst_resp.valid", {31'b0, valid_o}, 32'h0);
    chk("rst_resp.rd", rd_o, 32'h0);
    @(negedge clk_i);
    chk("rst_resp.valid2", {31'b0, valid_o}, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_resp.ready", {31'b0, ready_o}, 32'h1);
    chk("rst_resp.valid3", {31'b0, valid_o}, 32'h0);

    // Store during reset must not land
    txn(100, '{1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0});
    rst_i = 1'b1; req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; a_i = 32'h20; wd_i = 32'h1234;
    @(negedge clk_i);
    rst_i = 1'b0; req_i = 1'b0;
    txn(101, '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
